// File: rtl/int2fl_seq.sv
// int2fl_seq: sequential signed-integer to packed-float converter.
// Output word is {s, e, m}: value = (-1)^s * m * 2^e. The mantissa m has an
// explicit leading one at bit MAN-1. Normalisation shifts the magnitude left
// by one bit per cycle until its MSB is set.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. in_ready and out_valid are decoded from the state
// register only, so neither has a combinational path from any input. A source
// must hold in_valid/in_data until it sees in_ready. The block holds out_valid
// and out_data stable until out_ready is high.
module int2fl_seq #(
  parameter int NBITS = 32,
  parameter int EXP   = 8,
  parameter int MAN   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBITS-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [MAN+EXP:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int OW = MAN + EXP + 1;
  // Exponent of a magnitude whose MSB was already set (no shifts needed).
  localparam logic [EXP-1:0] E_BASE = EXP'(NBITS - MAN);
  // Exponent code for an exact zero: the most negative exponent value.
  localparam logic [EXP-1:0] E_ZERO = {1'b1, {(EXP-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              s_q;
  logic [NBITS-1:0]  mag_q;
  logic [KW-1:0]     k_q;
  logic [OW-1:0]     out_q;

  logic              accept;
  logic              release_out;
  logic [NBITS-1:0]  in_abs;
  logic [NBITS-1:0]  mag_shl;
  logic [KW-1:0]     k_inc;

  // Build the packed word from a normalised magnitude and its shift count.
  // Bits below the mantissa field are dropped (truncation, no rounding).
  function automatic logic [OW-1:0] pack_word(input logic             s,
                                              input logic [NBITS-1:0] mag,
                                              input logic [KW-1:0]    k);
    logic [EXP-1:0] e;
    e = E_BASE - EXP'(k);
    return {s, e, mag[NBITS-1 -: MAN]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_q;

  // Handshake qualifiers and datapath helpers.
  always_comb begin
    accept      = in_valid && (state == IDLE);
    release_out = out_ready && (state == DONE);
    // Two's-complement negate. The most negative input maps to 2^(NBITS-1).
    in_abs      = in_data[NBITS-1] ? (~in_data + NBITS'(1)) : in_data;
    mag_shl     = mag_q << 1;
    k_inc       = k_q + KW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_abs == '0)          state_nxt = DONE;
          else if (in_abs[NBITS-1])  state_nxt = DONE;
          else                       state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (mag_shl[NBITS-1]) state_nxt = DONE;
      end
      DONE: begin
        if (release_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-cycle normalisation shift and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= 1'b0;
      mag_q <= '0;
      k_q   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_q   <= in_data[NBITS-1];
            mag_q <= in_abs;
            k_q   <= '0;
            if (in_abs == '0)
              out_q <= {1'b0, E_ZERO, {MAN{1'b0}}};
            else if (in_abs[NBITS-1])
              out_q <= pack_word(in_data[NBITS-1], in_abs, '0);
          end
        end
        SHIFT: begin
          mag_q <= mag_shl;
          k_q   <= k_inc;
          if (mag_shl[NBITS-1])
            out_q <= pack_word(s_q, mag_shl, k_inc);
        end
        default: begin
          // DONE: result held until the consumer takes it.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int2fl_seq.sv
// Directed bench for int2fl_seq at NBITS=32, EXP=8, MAN=23.
module tb_int2fl_seq;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  int2fl_seq #(.NBITS(32), .EXP(8), .MAN(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endfunction

  // Wait for out_valid, counting cycles after the accept edge.
  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat >= 100) begin
        total++;
        bad++;
        $display("FAIL %s: timeout after %0d cycles, want out_valid", name, lat);
        break;
      end
    end
  endtask

  // Present one operand at a negedge, let it be accepted, scramble the bus.
  task automatic send(input string name, input logic [31:0] d);
    @(negedge clk);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // One-cycle output handshake starting at a negedge with out_valid high.
  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [31:0] expv;

    total = 0;
    bad   = 0;
    vecs[0] = '{32'h0000_0001, 32'h7540_0000, 32};
    vecs[1] = '{32'hFFFF_FFFA, 32'hF660_0000, 30};
    vecs[2] = '{32'h0000_0000, 32'h4000_0000, 1};
    vecs[3] = '{32'h8000_0000, 32'h84C0_0000, 1};
    vecs[4] = '{32'h7FFF_FFFF, 32'h047F_FFFF, 2};
    vecs[5] = '{32'h0000_0003, 32'h75E0_0000, 31};
    vecs[6] = '{32'h1234_5678, 32'h0348_D159, 4};
    vecs[7] = '{32'hFFFF_FFFF, 32'hF540_0000, 32};
    vecs[8] = '{32'h4000_0000, 32'h0440_0000, 2};
    vecs[9] = '{32'h8000_0001, 32'h847F_FFFF, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Table-driven conversions.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].dout);
      send($sformatf("vec%0d", i), vecs[i].din);
      wait_out($sformatf("vec%0d", i), lat);
      expv = exp_q.pop_front();
      check($sformatf("vec%0d_data", i), out_data, expv);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      take_out();
    end

    // in_valid held high and in_data changed mid-conversion.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h7FFF_FFFF;
    @(posedge clk);
    #1 in_data = 32'h0000_0005;
    @(negedge clk);
    check("hold_in_ready_1",  {31'd0, in_ready},  32'd0);
    check("hold_out_valid_1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("hold_out_valid_2", {31'd0, out_valid}, 32'd1);
    check("hold_in_ready_2",  {31'd0, in_ready},  32'd0);
    check("hold_data",        out_data,           32'h047F_FFFF);
    in_valid = 1'b0;
    take_out();

    // Backpressure: result stays put for 10 cycles with out_ready low.
    send("bp", 32'h1234_5678);
    wait_out("bp", lat);
    held = 32'h0348_D159;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_data_%0d", c), out_data, held);
      if (!out_valid || in_ready) begin
        total++;
        bad++;
        $display("FAIL bp_flags_%0d: out_valid=%0b in_ready=%0b want 1/0",
                 c, out_valid, in_ready);
      end else begin
        total++;
      end
    end
    take_out();
    @(negedge clk);
    check("bp_post_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_post_in_ready",  {31'd0, in_ready},  32'd1);

    // Reset mid-conversion discards the operand.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data",  out_data,           32'd0);
    send("post_rst", 32'h0000_0003);
    wait_out("post_rst", lat);
    check("post_rst_data", out_data, 32'h75E0_0000);
    check("post_rst_lat",  32'(lat), 32'd31);
    take_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
